vote_collector: RTL and testbench

VOTE_COLLECTOR -- requirements
Module: vote_collector

---
 rtl/vote_collector.sv | 143 ++++++++++++++
 tb/tb_vote_collector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_collector.sv
// Vote collector: gathers up to five single-bit votes into a frame for the
// 5-input majority stage, closing early on an idle timeout.
module vote_collector #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       vote_valid,
  input  logic       vote_bit,
  output logic       vote_ready,
  output logic [4:0] votes,
  output logic       votes_valid,
  input  logic       votes_ack,
  output logic       partial,
  output logic [2:0] ones_cnt
);

  localparam int unsigned NVOTES = 5;
  localparam int unsigned CW     = 3;
  localparam int unsigned TW     = 8;

  localparam logic [CW-1:0] COUNT_LAST = CW'(NVOTES - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(NVOTES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NVOTES-1:0] votes_d;
  logic [2:0]        ones_d;
  logic              partial_d;
  logic              valid_d;

  // Readiness depends on state alone so upstream never sees a combinational path.
  assign vote_ready = (state_q != HOLD);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      timer_q     <= '0;
      votes       <= '0;
      ones_cnt    <= '0;
      partial     <= 1'b0;
      votes_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      votes       <= votes_d;
      ones_cnt    <= ones_d;
      partial     <= partial_d;
      votes_valid <= valid_d;
    end
  end

  // Next-state and next-output decode; clear overrides everything.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timer_d   = timer_q;
    votes_d   = votes;
    ones_d    = ones_cnt;
    partial_d = partial;
    valid_d   = votes_valid;

    if (clear) begin
      state_d   = IDLE;
      count_d   = '0;
      timer_d   = '0;
      votes_d   = '0;
      ones_d    = '0;
      partial_d = 1'b0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (vote_valid) begin
            votes_d = NVOTES'(vote_bit);
            ones_d  = 3'(vote_bit);
            count_d = CW'(1);
            timer_d = '0;
            state_d = COLLECT;
          end
        end

        COLLECT: begin
          if (vote_valid) begin
            votes_d = votes | (NVOTES'(vote_bit) << count_q);
            ones_d  = ones_cnt + 3'(vote_bit);
            timer_d = '0;
            if (count_q >= COUNT_LAST) begin
              count_d = COUNT_FULL;
              state_d = HOLD;
              valid_d = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
            end
          end else if (timer_q >= TIMER_LAST) begin
            // Unfilled bits are already zero from the IDLE entry.
            timer_d   = '0;
            state_d   = HOLD;
            valid_d   = 1'b1;
            partial_d = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        HOLD: begin
          if (votes_ack) begin
            state_d   = IDLE;
            count_d   = '0;
            timer_d   = '0;
            votes_d   = '0;
            ones_d    = '0;
            partial_d = 1'b0;
            valid_d   = 1'b0;
          end
        end

        default: begin
          state_d   = IDLE;
          count_d   = '0;
          timer_d   = '0;
          votes_d   = '0;
          ones_d    = '0;
          partial_d = 1'b0;
          valid_d   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_collector.sv
// Scoreboard bench for vote_collector: directed frames push expected results,
// a negedge monitor pops them when votes_valid rises.
module tb_vote_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       vote_valid;
  logic       vote_bit;
  logic       vote_ready;
  logic [4:0] votes;
  logic       votes_valid;
  logic       votes_ack;
  logic       partial;
  logic [2:0] ones_cnt;

  typedef struct {
    logic [4:0] v;
    logic [2:0] o;
    logic       p;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  exp_t e_push;

  int n_checks = 0;
  int n_fail   = 0;

  logic       prev_valid = 1'b0;
  logic [4:0] held_votes = '0;

  vote_collector #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .vote_valid (vote_valid),
    .vote_bit   (vote_bit),
    .vote_ready (vote_ready),
    .votes      (votes),
    .votes_valid(votes_valid),
    .votes_ack  (votes_ack),
    .partial    (partial),
    .ones_cnt   (ones_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vote(input logic b);
    vote_valid = 1'b1;
    vote_bit   = b;
    @(posedge clk);
    #1;
    vote_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [4:0] v, input logic [2:0] o, input logic p);
    e_push.v = v;
    e_push.o = o;
    e_push.p = p;
    sb.push_back(e_push);
  endtask

  // Monitor: compare each new frame against the scoreboard, then watch it stay stable.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && votes_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_frame", 32'(votes_valid), 32'd0);
      end else begin
        e_mon = sb.pop_front();
        check("frame_votes",   32'(votes),    32'(e_mon.v));
        check("frame_ones",    32'(ones_cnt), 32'(e_mon.o));
        check("frame_partial", 32'(partial),  32'(e_mon.p));
      end
      held_votes = votes;
    end else if (votes_valid === 1'b1 && prev_valid === 1'b1) begin
      check("hold_stable", 32'(votes), 32'(held_votes));
    end
    prev_valid = votes_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    vote_valid = 1'b0;
    vote_bit   = 1'b0;
    votes_ack  = 1'b0;

    // Reset state
    cyc(2);
    check("rst_votes",   32'(votes),       32'd0);
    check("rst_valid",   32'(votes_valid), 32'd0);
    check("rst_partial", 32'(partial),     32'd0);
    check("rst_ones",    32'(ones_cnt),    32'd0);
    check("rst_ready",   32'(vote_ready),  32'd1);
    rst_n = 1'b1;
    cyc(1);

    // Full frame 1,1,1,0,0
    expect_frame(5'b00111, 3'd3, 1'b0);
    vote(1'b1);
    vote(1'b1);
    vote(1'b1);
    vote(1'b0);
    check("full_pre_valid", 32'(votes_valid), 32'd0);
    vote(1'b0);
    check("full_valid_latency", 32'(votes_valid), 32'd1);
    check("full_ready_low",     32'(vote_ready),  32'd0);
    cyc(1);
    votes_ack = 1'b1;
    cyc(1);
    votes_ack = 1'b0;
    check("ack_valid_clr", 32'(votes_valid), 32'd0);
    check("ack_votes_clr", 32'(votes),       32'd0);
    check("ack_ready",     32'(vote_ready),  32'd1);

    // Timeout: 1,0 then 16 idle cycles
    expect_frame(5'b00001, 3'd1, 1'b1);
    vote(1'b1);
    vote(1'b0);
    cyc(15);
    check("timeout_not_yet", 32'(votes_valid), 32'd0);
    cyc(1);
    check("timeout_valid",   32'(votes_valid), 32'd1);
    check("timeout_partial", 32'(partial),     32'd1);

    // Backpressure in HOLD
    vote_valid = 1'b1;
    vote_bit   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("bp_ready", 32'(vote_ready), 32'd0);
      check("bp_votes", 32'(votes),      32'd1);
      check("bp_ones",  32'(ones_cnt),   32'd1);
    end
    // Ack with a vote still offered: the vote must not be taken this cycle
    votes_ack = 1'b1;
    cyc(1);
    votes_ack = 1'b0;
    check("bp_ack_votes",   32'(votes),       32'd0);
    check("bp_ack_valid",   32'(votes_valid), 32'd0);
    check("bp_ack_partial", 32'(partial),     32'd0);
    check("bp_ack_ready",   32'(vote_ready),  32'd1);
    expect_frame(5'b10101, 3'd3, 1'b0);
    cyc(1);
    check("bp_next_bit0", 32'(votes), 32'd1);
    vote(1'b0);
    vote(1'b1);
    vote(1'b0);
    vote(1'b1);
    check("bp_frame_valid", 32'(votes_valid), 32'd1);
    votes_ack = 1'b1;
    cyc(1);
    votes_ack = 1'b0;

    // Clear mid-frame with a vote offered
    vote(1'b1);
    vote(1'b1);
    vote(1'b1);
    check("pre_clear_votes", 32'(votes), 32'd7);
    vote_valid = 1'b1;
    vote_bit   = 1'b1;
    clear      = 1'b1;
    cyc(1);
    clear      = 1'b0;
    vote_valid = 1'b0;
    check("clear_votes", 32'(votes),       32'd0);
    check("clear_ones",  32'(ones_cnt),    32'd0);
    check("clear_valid", 32'(votes_valid), 32'd0);
    check("clear_ready", 32'(vote_ready),  32'd1);
    cyc(1);
    check("clear_dropped", 32'(votes), 32'd0);

    // Stray acks in IDLE and COLLECT
    votes_ack = 1'b1;
    cyc(1);
    votes_ack = 1'b0;
    check("stray_idle_votes", 32'(votes),       32'd0);
    check("stray_idle_valid", 32'(votes_valid), 32'd0);
    vote(1'b1);
    votes_ack = 1'b1;
    cyc(1);
    votes_ack = 1'b0;
    check("stray_col_votes", 32'(votes),       32'd1);
    check("stray_col_ones",  32'(ones_cnt),    32'd1);
    check("stray_col_valid", 32'(votes_valid), 32'd0);
    expect_frame(5'b10001, 3'd2, 1'b0);
    vote(1'b0);
    vote(1'b0);
    vote(1'b0);
    vote(1'b1);
    check("stray_frame_valid", 32'(votes_valid), 32'd1);

    // Clear while holding a frame
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clear_hold_valid", 32'(votes_valid), 32'd0);
    check("clear_hold_votes", 32'(votes),       32'd0);

    // Asynchronous reset mid-COLLECT
    vote(1'b1);
    vote(1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_votes",   32'(votes),       32'd0);
    check("async_rst_ones",    32'(ones_cnt),    32'd0);
    check("async_rst_valid",   32'(votes_valid), 32'd0);
    check("async_rst_partial", 32'(partial),     32'd0);
    check("async_rst_ready",   32'(vote_ready),  32'd1);
    #2;
    rst_n = 1'b1;
    cyc(1);
    check("post_rst_ready", 32'(vote_ready), 32'd1);
    vote(1'b1);
    check("post_rst_bit0", 32'(votes),       32'd1);
    check("post_rst_ones", 32'(ones_cnt),    32'd1);
    check("post_rst_valid", 32'(votes_valid), 32'd0);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(2);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
